// File: rtl/mem_port_arbiter_if.sv
// Bundle of every handshake and bus signal around mem_port_arbiter.
//   master : the arbiter's view. It takes the IF/DM requests and the memory response, and it
//            drives the acks, read data, err, the mux select and the memory strobes.
//   slave  : the environment's view. It holds the requesters and the memory.
interface mem_port_arbiter_if;
  logic        if_req;
  logic [31:0] if_addr;
  logic [31:0] if_rdata;
  logic        if_ack;

  logic        dm_req;
  logic        dm_we;
  logic [31:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_ack;

  logic        err;
  logic        sel;

  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_ready;

  modport master (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    output if_rdata, if_ack, dm_rdata, dm_ack, err, sel, mem_en, mem_we, mem_addr, mem_wdata
  );

  modport slave (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, mem_rdata, mem_ready,
    input  if_rdata, if_ack, dm_rdata, dm_ack, err, sel, mem_en, mem_we, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: lets instruction fetch (IF) and data access (DM) share one single-ported
// memory. Each access runs through three phases. The arbiter picks a requester in IDLE. It
// holds the grant until mem_ready arrives. It then spends one RESP cycle that carries the ack
// pulse and the read data. DM has priority over IF. After STREAK_MAX back-to-back DM grants
// with IF waiting, IF gets the next grant. If a grant sees no mem_ready within TIMEOUT cycles,
// a watchdog aborts the access, reports err and returns zero data.
// Ports:
//   clk    : clock. All state changes on the rising edge.
//   rst_n  : asynchronous active-low reset (the Reset pin).
//   bus    : mem_port_arbiter_if.master, which carries the IF/DM request channels, the ack
//            and err pulses, the mux select and the memory port.
module mem_port_arbiter #(
  parameter int unsigned STREAK_MAX = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input logic                clk,
  input logic                rst_n,
  mem_port_arbiter_if.master bus
);

  localparam int unsigned StreakW = $clog2(STREAK_MAX + 1);
  localparam int unsigned WdogW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [StreakW-1:0] StreakMax = StreakW'(STREAK_MAX);
  localparam logic [WdogW-1:0]   WdogLast  = WdogW'(TIMEOUT - 1);

  typedef enum logic [1:0] {StIdle, StGntIf, StGntDm, StResp} state_e;

  state_e               state_q, state_d;
  logic                 sel_q, sel_d;
  logic [StreakW-1:0]   streak_q, streak_d;
  logic [WdogW-1:0]     wdog_q, wdog_d;
  logic                 if_ack_q, if_ack_d;
  logic                 dm_ack_q, dm_ack_d;
  logic                 err_q, err_d;
  logic [31:0]          if_rdata_q, if_rdata_d;
  logic [31:0]          dm_rdata_q, dm_rdata_d;

  always_comb begin
    state_d    = state_q;
    sel_d      = sel_q;
    streak_d   = streak_q;
    wdog_d     = '0;
    if_ack_d   = 1'b0;
    dm_ack_d   = 1'b0;
    err_d      = 1'b0;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      StIdle: begin
        // IF takes the grant only once DM has won STREAK_MAX times in a row while IF waited.
        if (bus.dm_req && !(bus.if_req && (streak_q == StreakMax))) begin
          state_d = StGntDm;
          sel_d   = 1'b1;
          // Reaching this branch with if_req high implies streak_q < STREAK_MAX, so no wrap.
          streak_d = bus.if_req ? (streak_q + 1'b1) : '0;
        end else if (bus.if_req) begin
          state_d  = StGntIf;
          sel_d    = 1'b0;
          streak_d = '0;
        end else begin
          streak_d = '0;
        end
      end

      StGntIf, StGntDm: begin
        if (bus.mem_ready) begin
          state_d = StResp;
          if (state_q == StGntIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus.mem_rdata;
          end else begin
            dm_ack_d = 1'b1;
            // A write returns no data, so dm_rdata keeps its previous value.
            if (!bus.dm_we) dm_rdata_d = bus.mem_rdata;
          end
        end else if (wdog_q == WdogLast) begin
          state_d = StResp;
          err_d   = 1'b1;
          if (state_q == StGntIf) begin
            if_ack_d   = 1'b1;
            if_rdata_d = '0;
          end else begin
            dm_ack_d   = 1'b1;
            dm_rdata_d = '0;
          end
        end else begin
          wdog_d = wdog_q + 1'b1;
        end
      end

      StResp: state_d = StIdle;

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      sel_q      <= 1'b0;
      streak_q   <= '0;
      wdog_q     <= '0;
      if_ack_q   <= 1'b0;
      dm_ack_q   <= 1'b0;
      err_q      <= 1'b0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      sel_q      <= sel_d;
      streak_q   <= streak_d;
      wdog_q     <= wdog_d;
      if_ack_q   <= if_ack_d;
      dm_ack_q   <= dm_ack_d;
      err_q      <= err_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign bus.if_ack    = if_ack_q;
  assign bus.dm_ack    = dm_ack_q;
  assign bus.err       = err_q;
  assign bus.if_rdata  = if_rdata_q;
  assign bus.dm_rdata  = dm_rdata_q;
  assign bus.sel       = sel_q;
  assign bus.mem_en    = (state_q == StGntIf) || (state_q == StGntDm);
  assign bus.mem_we    = (state_q == StGntDm) && bus.dm_we;
  assign bus.mem_addr  = sel_q ? bus.dm_addr : bus.if_addr;
  assign bus.mem_wdata = bus.dm_wdata;

endmodule
